dmem_store_buffer: RTL

//  Data-memory stage downstream of the ARM core. It consumes MemWrite/DataAdr/WriteData and returns ReadData.

---
 rtl/arm_pkg.sv | 14 +
 rtl/sb_fifo.sv | 64 ++++++
 rtl/dmem_store_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared constants and the store-buffer entry type for the data-memory stage.
// Store-to-load forwarding in dmem_store_buffer is selected by the DMEM_SB_FWD_EN macro.
package arm_pkg;

  localparam int SB_DEPTH   = 4;
  localparam int DMEM_WORDS = 64;
  localparam int DMEM_IDX_W = $clog2(DMEM_WORDS);

  typedef struct packed {
    logic [DMEM_IDX_W-1:0] idx;
    logic [31:0]           data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store-buffer FIFO: head/tail/count, entry array, and an idx-compare
// vector presented in age order (bit 0 = oldest pending entry).
module sb_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  sb_entry_t              pushEntry,
  input  logic                   pop,
  input  logic [DMEM_IDX_W-1:0]  lookupIdx,
  output sb_entry_t              headEntry,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       matchAge,
  output logic [DEPTH-1:0][31:0] dataAge
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] ageSlot [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= pushEntry;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign headEntry = entries[head];

  // Walk from head so bit k is the k-th oldest; slots at or beyond count are stale.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ageSlot[k]  = head + PTR_W'(k);
      matchAge[k] = (CNT_W'(k) < count) && (entries[ageSlot[k]].idx == lookupIdx);
      dataAge[k]  = entries[ageSlot[k]].data;
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory stage: posted-store FIFO draining into a word RAM on idle cycles.
// DMEM_SB_FWD_EN defined: loads forward from the youngest buffered store; otherwise matching loads stall.
module dmem_store_buffer
  import arm_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int MEM_WORDS = DMEM_WORDS,
  parameter int IDX_W     = DMEM_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BufEmpty
);

  logic [31:0]            mem [MEM_WORDS];
  logic [IDX_W-1:0]       adrIdx;
  logic                   unusedAdrBits;
  logic                   loadReq;
  logic                   anyMatch;
  logic                   loadStall;
  logic                   loadAccepted;
  logic                   enq;
  logic                   drain;
  logic                   full;
  logic                   empty;
  logic [DEPTH-1:0]       matchAge;
  logic [DEPTH-1:0][31:0] dataAge;
  sb_entry_t              pushEntry;
  sb_entry_t              headEntry;
  logic [31:0]            fwdData;
  logic [31:0]            ramData;
  logic [31:0]            readSel;

  assign adrIdx        = DataAdr[IDX_W+1:2];
  assign unusedAdrBits = ^{DataAdr[31:IDX_W+2], DataAdr[1:0]};

  assign pushEntry.idx  = adrIdx;
  assign pushEntry.data = WriteData;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (enq),
    .pushEntry (pushEntry),
    .pop       (drain),
    .lookupIdx (adrIdx),
    .headEntry (headEntry),
    .full      (full),
    .empty     (empty),
    .matchAge  (matchAge),
    .dataAge   (dataAge)
  );

  assign loadReq  = MemRead && !MemWrite;
  assign anyMatch = |matchAge;
  assign ramData  = mem[adrIdx];

  // Later (younger) matches override earlier ones.
  always_comb begin
    fwdData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (matchAge[k]) begin
        fwdData = dataAge[k];
      end
    end
  end

`ifdef DMEM_SB_FWD_EN
  assign loadStall = 1'b0;
`else
  assign loadStall = loadReq && anyMatch;
`endif

  // While a matching load is stalled its data is ignored, so the forward mux is shared by both builds.
  assign readSel = anyMatch ? fwdData : ramData;

  assign loadAccepted = loadReq && !loadStall;
  assign enq          = !reset && MemWrite && !full;
  assign drain        = !reset && !empty && !enq && !loadAccepted;

  always_ff @(posedge clk) begin
    if (drain) begin
      mem[headEntry.idx] <= headEntry.data;
    end
  end

  assign Stall    = !reset && (MemWrite ? full : loadStall);
  assign BufEmpty = reset || empty;
  assign ReadData = (!reset && loadReq) ? readSel : 32'h0;

endmodule
